// File: rtl/rks_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rks_pkg
// Description : Shared types and helpers for the RKS tape image loader:
//               FSM state encoding, load error codes and the checksum step.
// Revision    : 1.0 - initial release
// ============================================================================
package rks_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_HDR   = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_TRUNC = 2'd3;

    // Every payload byte but the last adds b*257 ({b,b}); the last byte only
    // adds into the low byte and its carry is lost.
    function automatic logic [15:0] csum_step(
        input logic [15:0] c,
        input logic [7:0]  b,
        input logic        last
    );
        logic [7:0] w_lo;
        w_lo = c[7:0] + b;
        if (last)
            return {c[15:8], w_lo};
        else
            return c + {b, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rks_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rks_fifo
// Description : Small synchronous FIFO holding {addr,data} write entries.
//               Push and pop may occur in the same cycle; a push into a full
//               FIFO is ignored unless a pop frees a slot in that cycle.
// Ports       : clk_sys, reset  - clock, synchronous active-high reset
//               i_clr           - synchronous flush
//               i_push, i_din   - write strobe and entry
//               i_pop           - consume head entry
//               o_dout          - head entry (valid when !o_empty)
//               o_empty, o_full - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module rks_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == C_DEPTH);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rp];

    always_ff @(posedge clk_sys) begin
        if (w_do_push)
            r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk_sys) begin
        if (reset || i_clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push)
                r_wp <= r_wp + 1'b1;
            if (w_do_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rks_loader.sv
`default_nettype none
// ============================================================================
// Module      : rks_loader
// Description : Parses an RKS tape image streamed from the ioctl interface,
//               writes the payload to SRAM at the header address, verifies the
//               checksum and reports the load result.
// Ports       : clk_sys, reset       - clock, synchronous active-high reset
//               i_load               - download active
//               i_in_wr, i_in_data   - file byte strobe and value
//               o_mem_we/addr/din    - SRAM write request, held until ack
//               i_mem_ack            - SRAM accepts the current request
//               o_busy               - load in progress or writes pending
//               o_done               - one-cycle pulse, image OK and written
//               o_error              - sticky result code (see rks_pkg)
//               o_start_addr         - header start address
// Revision    : 1.0 - initial release
// ============================================================================
module rks_loader
    import rks_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_in_wr,
    input  logic [7:0]  i_in_data,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_din,
    input  logic        i_mem_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_error,
    output logic [15:0] o_start_addr
);
    state_t      r_state;
    logic        r_load_d;
    logic [1:0]  r_cnt;
    logic [15:0] r_s;
    logic [7:0]  r_e_lo;
    logic [7:0]  r_ck_lo;
    logic [16:0] r_rem;
    logic [15:0] r_addr;
    logic [15:0] r_csum;
    logic        r_done_sent;

    logic        w_rise;
    logic        w_fall;
    logic        w_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic [23:0] w_head;
    logic [15:0] w_e;

    assign w_rise = i_load & ~r_load_d;
    assign w_fall = ~i_load & r_load_d;
    assign w_acc  = i_in_wr & i_load;
    assign w_e    = {i_in_data, r_e_lo};
    assign w_pop  = i_mem_ack & ~w_empty;
    // A byte arriving with the FIFO full and no pop is dropped (see FSM).
    assign w_push = w_acc & ~w_rise & (r_state == ST_DATA) & (~w_full | w_pop);

    rks_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_clr   (w_rise),
        .i_push  (w_push),
        .i_din   ({r_addr, i_in_data}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Outputs are forced to zero when idle so the bus is clean after reset.
    assign o_mem_we   = ~w_empty;
    assign o_mem_addr = w_empty ? 16'h0000 : w_head[23:8];
    assign o_mem_din  = w_empty ? 8'h00    : w_head[7:0];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_load_d     <= 1'b0;
            r_cnt        <= 2'd0;
            r_s          <= 16'h0000;
            r_e_lo       <= 8'h00;
            r_ck_lo      <= 8'h00;
            r_rem        <= 17'd0;
            r_addr       <= 16'h0000;
            r_csum       <= 16'h0000;
            r_done_sent  <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= ERR_NONE;
            o_start_addr <= 16'h0000;
        end else begin
            r_load_d <= i_load;
            o_done   <= 1'b0;
            if (w_rise) begin
                r_state     <= ST_HDR;
                r_cnt       <= 2'd0;
                r_csum      <= 16'h0000;
                r_done_sent <= 1'b0;
                o_error     <= ERR_NONE;
                o_busy      <= 1'b1;
            end else begin
                if ((r_state == ST_DONE || r_state == ST_ERR) && w_empty)
                    o_busy <= 1'b0;
                // done waits for the last payload write to be accepted
                if (r_state == ST_DONE && w_empty && !r_done_sent) begin
                    o_done      <= 1'b1;
                    r_done_sent <= 1'b1;
                end
                if (w_fall && (r_state == ST_HDR || r_state == ST_DATA ||
                               r_state == ST_CSUM)) begin
                    r_state <= ST_ERR;
                    o_error <= ERR_TRUNC;
                end else if (w_acc) begin
                    case (r_state)
                        ST_HDR: begin
                            r_cnt <= r_cnt + 2'd1;
                            case (r_cnt)
                                2'd0: r_s[7:0] <= i_in_data;
                                2'd1: begin
                                    r_s[15:8]    <= i_in_data;
                                    o_start_addr <= {i_in_data, r_s[7:0]};
                                end
                                2'd2: r_e_lo <= i_in_data;
                                default: begin
                                    if (w_e < r_s) begin
                                        r_state <= ST_ERR;
                                        o_error <= ERR_HDR;
                                    end else begin
                                        r_rem   <= {1'b0, w_e} - {1'b0, r_s} + 17'd1;
                                        r_addr  <= r_s;
                                        r_state <= ST_DATA;
                                    end
                                end
                            endcase
                        end
                        ST_DATA: begin
                            if (w_full && !w_pop) begin
                                r_state <= ST_ERR;
                                o_error <= ERR_TRUNC;
                            end else begin
                                r_addr <= r_addr + 16'd1;
                                r_rem  <= r_rem - 17'd1;
                                r_csum <= csum_step(r_csum, i_in_data, r_rem == 17'd1);
                                if (r_rem == 17'd1) begin
                                    r_state <= ST_CSUM;
                                    r_cnt   <= 2'd0;
                                end
                            end
                        end
                        ST_CSUM: begin
                            r_cnt <= r_cnt + 2'd1;
                            if (r_cnt == 2'd0) begin
                                r_ck_lo <= i_in_data;
                            end else if ({i_in_data, r_ck_lo} == r_csum) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_state <= ST_ERR;
                                o_error <= ERR_CSUM;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rks_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rks_loader
// Description : Self-checking bench for rks_loader. A randomised SRAM
//               responder pops expected writes from a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rks_loader;
    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        load    = 1'b0;
    logic        in_wr   = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  error;
    logic [15:0] start_addr;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          we_cnt   = 0;
    logic        hold     = 1'b0;
    logic [23:0] q_exp [$];
    logic [15:0] addr_m;
    logic [15:0] csum_m;

    always #5 clk_sys = ~clk_sys;

    rks_loader #(.FIFO_DEPTH(4)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .i_load       (load),
        .i_in_wr      (in_wr),
        .i_in_data    (in_data),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_din    (mem_din),
        .i_mem_ack    (mem_ack),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_start_addr (start_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // SRAM responder and scoreboard
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk_sys);
            if (!reset && mem_we && !hold && $urandom_range(0, 2) != 0) begin
                if (q_exp.size() == 0) begin
                    check("unexp_wr", {8'h00, mem_addr, mem_din}, 32'hFFFFFFFF);
                end else begin
                    e = q_exp.pop_front();
                    check("wr", {8'h00, mem_addr, mem_din}, {8'h00, e});
                end
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (done)   done_cnt++;
            if (mem_we) we_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic put(input logic [7:0] b, input logic chk);
        @(negedge clk_sys);
        in_wr   = 1'b1;
        in_data = b;
        @(negedge clk_sys);
        in_wr = 1'b0;
        if (chk) check("lat_we", {31'd0, mem_we}, 32'd1);
        repeat (7) @(negedge clk_sys);
    endtask

    task automatic send_hdr(input logic [15:0] s, input logic [15:0] e);
        put(s[7:0], 1'b0);
        put(s[15:8], 1'b0);
        put(e[7:0], 1'b0);
        put(e[15:8], 1'b0);
        addr_m = s;
        csum_m = 16'h0000;
    endtask

    task automatic send_data(input logic [7:0] b, input logic last);
        q_exp.push_back({addr_m, b});
        addr_m = addr_m + 16'd1;
        if (last) csum_m[7:0] = csum_m[7:0] + b;
        else      csum_m = csum_m + 16'(b) * 16'd257;
        put(b, 1'b1);
    endtask

    task automatic begin_load();
        @(negedge clk_sys);
        load = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic end_load_wait(input string tag);
        @(negedge clk_sys);
        load = 1'b0;
        for (int i = 0; i < 300 && busy; i++) @(negedge clk_sys);
        check(tag, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},   {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        check({tag, "_din"},  {24'd0, mem_din}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"},  {30'd0, error}, 32'd0);
        check({tag, "_sa"},   {16'd0, start_addr}, 32'd0);
    endtask

    initial begin
        int          d0;
        int          w0;
        logic [24:0] snap;

        repeat (3) @(negedge clk_sys);
        check_reset_vals("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Happy path
        d0 = done_cnt;
        begin_load();
        check("hp_busy", {31'd0, busy}, 32'd1);
        send_hdr(16'h0000, 16'h0002);
        send_data(8'h01, 1'b0);
        send_data(8'h02, 1'b0);
        send_data(8'h03, 1'b1);
        put(8'h06, 1'b0);
        put(8'h03, 1'b0);
        end_load_wait("hp_idle");
        check("hp_done", done_cnt - d0, 1);
        check("hp_err", {30'd0, error}, 32'd0);
        check("hp_sa", {16'd0, start_addr}, 32'h0000);
        check("hp_q", q_exp.size(), 0);

        // Single-byte image
        d0 = done_cnt;
        begin_load();
        send_hdr(16'h9000, 16'h9000);
        send_data(8'hAA, 1'b1);
        put(8'hAA, 1'b0);
        put(8'h00, 1'b0);
        end_load_wait("sb_idle");
        check("sb_done", done_cnt - d0, 1);
        check("sb_err", {30'd0, error}, 32'd0);
        check("sb_sa", {16'd0, start_addr}, 32'h9000);
        check("sb_q", q_exp.size(), 0);

        // Bad header
        d0 = done_cnt;
        w0 = we_cnt;
        begin_load();
        send_hdr(16'h2000, 16'h1FFF);
        check("bh_err", {30'd0, error}, 32'd1);
        end_load_wait("bh_idle");
        check("bh_err2", {30'd0, error}, 32'd1);
        check("bh_we", we_cnt - w0, 0);
        check("bh_done", done_cnt - d0, 0);

        // Checksum mismatch
        d0 = done_cnt;
        begin_load();
        send_hdr(16'h0000, 16'h0002);
        send_data(8'h01, 1'b0);
        send_data(8'h02, 1'b0);
        send_data(8'h03, 1'b1);
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        end_load_wait("cs_idle");
        check("cs_err", {30'd0, error}, 32'd2);
        check("cs_done", done_cnt - d0, 0);
        check("cs_q", q_exp.size(), 0);

        // Backpressure then truncation
        d0 = done_cnt;
        hold = 1'b1;
        begin_load();
        send_hdr(16'h1234, 16'h1240);
        send_data(8'h5A, 1'b0);
        send_data(8'hA5, 1'b0);
        snap = {mem_we, mem_addr, mem_din};
        check("bp_head", {7'd0, snap}, {7'd0, 1'b1, 16'h1234, 8'h5A});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            check("bp_stable", {7'd0, mem_we, mem_addr, mem_din}, {7'd0, snap});
        end
        @(negedge clk_sys);
        load = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("tr_err", {30'd0, error}, 32'd3);
        check("tr_busy", {31'd0, busy}, 32'd1);
        hold = 1'b0;
        end_load_wait("tr_idle");
        check("tr_q", q_exp.size(), 0);
        check("tr_done", done_cnt - d0, 0);
        check("tr_err2", {30'd0, error}, 32'd3);

        // Reset mid-DATA, then a fresh load
        hold = 1'b1;
        begin_load();
        send_hdr(16'h4000, 16'h4005);
        send_data(8'h11, 1'b0);
        send_data(8'h22, 1'b0);
        @(negedge clk_sys);
        reset = 1'b1;
        load  = 1'b0;
        @(negedge clk_sys);
        check_reset_vals("mr");
        reset = 1'b0;
        q_exp.delete();
        hold = 1'b0;
        repeat (2) @(negedge clk_sys);
        d0 = done_cnt;
        begin_load();
        send_hdr(16'h4000, 16'h4001);
        send_data(8'h10, 1'b0);
        send_data(8'h20, 1'b1);
        put(8'h30, 1'b0);
        put(8'h10, 1'b0);
        end_load_wait("fr_idle");
        check("fr_done", done_cnt - d0, 1);
        check("fr_err", {30'd0, error}, 32'd0);
        check("fr_sa", {16'd0, start_addr}, 32'h4000);
        check("fr_q", q_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
